// File: rtl/fetch_stage.sv
// fetch_fifo: small instruction buffer (storage, pointers, occupancy) with a synchronous clear.
// Latency: a push is visible at head_dat/count on the cycle after the push edge.
// Backpressure: no flow control of its own; pop-when-empty and push-when-full (without a pop) are ignored.
module fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    push_vld,
   input  logic [W-1:0]            push_dat,
   input  logic                    pop_vld,
   output logic [W-1:0]            head_dat,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   // Next storage/pointer/occupancy state; clear wins over push and pop.
   always_comb begin
      do_pop  = pop_vld && (cnt_q != '0);
      do_push = push_vld && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (clr) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_d = rd_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_q];
   assign count    = cnt_q;
endmodule

// fetch_stage: MIPS IF stage; issues imem requests and buffers returned words with their PCs.
// Latency: f_valid rises one cycle after the ack edge; zero-wait memory sustains one instruction per cycle.
// Backpressure: f_stall holds the head; a request is only issued when a buffer slot is guaranteed for it.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        f_valid,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc
);
   localparam int          CW     = $clog2(IBUF_DEPTH) + 1;
   localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ibuf_entry_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] stale_q, stale_d;   // address of a squashed request still on the bus
   logic        push_vld, pop_vld;
   ibuf_entry_t push_dat, head_dat;
   logic [CW-1:0] count;
   logic [CW:0]   occ_next;
   logic          credit;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // A redirect discards whatever would have entered or left the buffer this edge.
   assign f_valid  = (count != '0);
   assign push_vld = (state_q == REQ) && imem_ack && !redirect;
   assign pop_vld  = f_valid && !f_stall && !redirect;
   assign push_dat = '{pc: pc_q, instr: imem_rdata};

   fetch_fifo #(
      .W     (64),
      .DEPTH (IBUF_DEPTH)
   ) u_ibuf (
      .clk      (clk),
      .reset    (reset),
      .clr      (redirect),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_vld  (pop_vld),
      .head_dat (head_dat),
      .count    (count)
   );

   // Occupancy after this edge decides whether another request can be covered by a free slot.
   always_comb begin
      occ_next = {1'b0, count};
      if (redirect) begin
         occ_next = '0;
      end else if (push_vld && !pop_vld) begin
         occ_next = occ_next + 1'b1;
      end else if (pop_vld && !push_vld) begin
         occ_next = occ_next - 1'b1;
      end
      credit = ((occ_next + 1'b1) <= (CW+1)'(IBUF_DEPTH));
   end

   // Request FSM plus fetch PC and stale-address tracking.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stale_d = stale_q;
      if (redirect) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (push_vld) begin
         pc_d = pc_q + 32'd4;
      end
      case (state_q)
         IDLE: begin
            if (redirect || credit) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               if (!imem_ack) begin
                  state_d = DROP;
                  stale_d = pc_q;
               end
            end else if (imem_ack) begin
               state_d = credit ? REQ : IDLE;
            end
         end
         DROP: begin
            // The squashed request must still complete; a further redirect only retargets pc.
            if (imem_ack) begin
               state_d = credit ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and PC registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= PC_RST;
         stale_q <= PC_RST;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
      end
   end

   assign imem_req  = (state_q != IDLE);
   assign imem_addr = (state_q == DROP) ? stale_q : pc_q;
   assign f_instr   = f_valid ? head_dat.instr : 32'h0;
   assign f_pc      = f_valid ? head_dat.pc    : 32'h0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scenario tasks against a scoreboard of expected {pc, instr} buffer entries.
// Inputs are driven and outputs sampled on the falling edge; the rising edge is the active one.
// Memory returns addr + 32'h1000, so each fetched word identifies the address it came from.
module tb_fetch_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, f_stall, redirect, imem_ack;
   logic [31:0] redirect_pc;
   logic        imem_req, f_valid;
   logic [31:0] imem_addr, imem_rdata, f_instr, f_pc;

   logic        reset_w, stall_w, redirect_w, ack_w;
   logic [31:0] redirect_pc_w;
   logic        imem_req_w, f_valid_w;
   logic [31:0] imem_addr_w, imem_rdata_w, f_instr_w, f_pc_w;

   assign imem_rdata   = imem_addr + 32'h1000;
   assign imem_rdata_w = imem_addr_w + 32'h1000;

   fetch_stage #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .f_stall(f_stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .f_valid(f_valid),
      .f_instr(f_instr), .f_pc(f_pc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IBUF_DEPTH(2)) dut_w (
      .clk(clk), .reset(reset_w), .f_stall(stall_w), .redirect(redirect_w),
      .redirect_pc(redirect_pc_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
      .imem_ack(ack_w), .imem_rdata(imem_rdata_w), .f_valid(f_valid_w),
      .f_instr(f_instr_w), .f_pc(f_pc_w)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   localparam logic [31:0] WEXP [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

   exp_t        sb[$];
   logic [31:0] exp_addr;
   logic        drop_pending;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Expected head: front of the scoreboard, or zeros when the buffer should be empty.
   function automatic exp_t exp_head();
      if (sb.size() != 0) return sb[0];
      return '0;
   endfunction

   // Apply this cycle's handshake to the model: pop first (new pushes are not visible yet), then push.
   task automatic sb_update();
      if (sb.size() != 0 && !f_stall) void'(sb.pop_front());
      if (imem_req && imem_ack) begin
         if (drop_pending) drop_pending = 1'b0;
         else begin
            sb.push_back({exp_addr, exp_addr + 32'h1000});
            exp_addr = exp_addr + 32'd4;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; f_stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({imem_req, imem_addr, f_valid, f_instr, f_pc} !== {1'b0, 32'h0, 1'b0, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_state: req=%0b addr=%h valid=%0b instr=%h pc=%h, required all zero",
                  imem_req, imem_addr, f_valid, f_instr, f_pc);
      end
      reset = 1'b1;
      sb.delete(); exp_addr = 32'h0; drop_pending = 1'b0;
   endtask

   task automatic test_stream();
      exp_t h;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         h = exp_head();
         n_tests++;
         if (f_valid !== (sb.size() != 0) || f_pc !== h.pc || f_instr !== h.instr) begin
            n_fail++;
            $display("FAIL stream_head k=%0d: valid=%0b pc=%h instr=%h, required valid=%0b pc=%h instr=%h",
                     k, f_valid, f_pc, f_instr, sb.size() != 0, h.pc, h.instr);
         end
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL stream_req k=%0d: req=%0b addr=%h, required req=1 addr=%h", k, imem_req, imem_addr, exp_addr);
         end
         f_stall = 1'b0; imem_ack = 1'b1;
         sb_update();
      end
   endtask

   task automatic test_stall();
      exp_t h;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         h = exp_head();
         n_tests++;
         if (f_valid !== (sb.size() != 0) || f_pc !== h.pc || f_instr !== h.instr) begin
            n_fail++;
            $display("FAIL stall_head k=%0d: valid=%0b pc=%h instr=%h, required valid=%0b pc=%h instr=%h",
                     k, f_valid, f_pc, f_instr, sb.size() != 0, h.pc, h.instr);
         end
         n_tests++;
         if (sb.size() > 2 || (sb.size() == 2 && imem_req !== 1'b0) || (imem_req && imem_addr !== exp_addr)) begin
            n_fail++;
            $display("FAIL stall_credit k=%0d: occupancy=%0d req=%0b addr=%h, required occupancy<=2, req=0 when full, addr=%h",
                     k, sb.size(), imem_req, imem_addr, exp_addr);
         end
         f_stall = (k >= 4 && k < 9); imem_ack = 1'b1;
         sb_update();
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         h = exp_head();
         n_tests++;
         if (f_valid !== (sb.size() != 0) || f_pc !== h.pc || f_instr !== h.instr) begin
            n_fail++;
            $display("FAIL drain_head k=%0d: valid=%0b pc=%h instr=%h, required valid=%0b pc=%h instr=%h",
                     k, f_valid, f_pc, f_instr, sb.size() != 0, h.pc, h.instr);
         end
         f_stall = 1'b0; imem_ack = 1'b0;
         sb_update();
      end
   endtask

   task automatic test_ack_delay();
      exp_t        h;
      int          waited;
      logic [31:0] a0;
      @(negedge clk);
      waited = 0;
      while (imem_req !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      n_tests++;
      if (imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_wait: req=%0b after %0d cycles, required req=1", imem_req, waited);
      end
      a0 = exp_addr;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== a0 || f_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_hold i=%0d: req=%0b addr=%h valid=%0b, required req=1 addr=%h valid=0",
                     i, imem_req, imem_addr, f_valid, a0);
         end
         f_stall = 1'b0; imem_ack = (i == 3);
         sb_update();
      end
      @(negedge clk);
      h = exp_head();
      n_tests++;
      if (f_valid !== 1'b1 || f_pc !== a0 || f_instr !== h.instr) begin
         n_fail++;
         $display("FAIL ack_push: valid=%0b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                  f_valid, f_pc, f_instr, a0, h.instr);
      end
      f_stall = 1'b0; imem_ack = 1'b0;
      sb_update();
      @(negedge clk);
      n_tests++;
      if (f_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_single: valid=%0b pc=%h, required valid=0 (exactly one push)", f_valid, f_pc);
      end
      sb_update();
   endtask

   task automatic test_redirect();
      exp_t        h;
      logic [31:0] stale;
      @(negedge clk);
      f_stall = 1'b1; imem_ack = 1'b1;
      sb_update();
      @(negedge clk);
      f_stall = 1'b1; imem_ack = 1'b0;
      sb_update();
      @(negedge clk);
      n_tests++;
      if (f_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== exp_addr) begin
         n_fail++;
         $display("FAIL redir_setup: valid=%0b req=%0b addr=%h, required valid=1 req=1 addr=%h",
                  f_valid, imem_req, imem_addr, exp_addr);
      end
      stale = exp_addr;
      redirect = 1'b1; redirect_pc = 32'h0000_0203; imem_ack = 1'b0; f_stall = 1'b1;
      sb.delete(); exp_addr = 32'h0000_0200; drop_pending = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      n_tests++;
      if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_instr !== 32'h0) begin
         n_fail++;
         $display("FAIL redir_flush: valid=%0b pc=%h instr=%h, required valid=0 pc=0 instr=0", f_valid, f_pc, f_instr);
      end
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== stale) begin
         n_fail++;
         $display("FAIL redir_stale: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, stale);
      end
      f_stall = 1'b0; imem_ack = 1'b1;
      sb_update();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         h = exp_head();
         n_tests++;
         if (f_valid !== (sb.size() != 0) || f_pc !== h.pc || f_instr !== h.instr) begin
            n_fail++;
            $display("FAIL redir_head k=%0d: valid=%0b pc=%h instr=%h, required valid=%0b pc=%h instr=%h",
                     k, f_valid, f_pc, f_instr, sb.size() != 0, h.pc, h.instr);
         end
         n_tests++;
         if (imem_req && imem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL redir_addr k=%0d: addr=%h, required %h", k, imem_addr, exp_addr);
         end
         f_stall = 1'b0; imem_ack = 1'b1;
         sb_update();
      end
   endtask

   task automatic test_async_reset();
      exp_t h;
      @(negedge clk);
      f_stall = 1'b1; imem_ack = 1'b0;
      sb_update();
      @(negedge clk);
      n_tests++;
      if (f_valid !== 1'b1 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_setup: valid=%0b req=%0b, required valid=1 req=1", f_valid, imem_req);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({imem_req, imem_addr, f_valid, f_instr, f_pc} !== {1'b0, 32'h0, 1'b0, 64'h0}) begin
         n_fail++;
         $display("FAIL arst_immediate: req=%0b addr=%h valid=%0b instr=%h pc=%h, required all zero",
                  imem_req, imem_addr, f_valid, f_instr, f_pc);
      end
      @(negedge clk);
      imem_ack = 1'b1; f_stall = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      n_tests++;
      if (imem_req !== 1'b0 || f_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_ack_ignored: req=%0b valid=%0b, required req=0 valid=0", imem_req, f_valid);
      end
      reset = 1'b1;
      sb.delete(); exp_addr = 32'h0; drop_pending = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         h = exp_head();
         n_tests++;
         if (f_valid !== (sb.size() != 0) || f_pc !== h.pc || f_instr !== h.instr ||
             imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL restart k=%0d: valid=%0b pc=%h instr=%h req=%0b addr=%h, required valid=%0b pc=%h instr=%h req=1 addr=%h",
                     k, f_valid, f_pc, f_instr, imem_req, imem_addr, sb.size() != 0, h.pc, h.instr, exp_addr);
         end
         f_stall = 1'b0; imem_ack = 1'b1;
         sb_update();
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      reset_w = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_tests++;
         if (imem_req_w !== 1'b1 || imem_addr_w !== WEXP[k-1]) begin
            n_fail++;
            $display("FAIL wrap_addr k=%0d: req=%0b addr=%h, required req=1 addr=%h", k, imem_req_w, imem_addr_w, WEXP[k-1]);
         end
         if (k >= 2) begin
            n_tests++;
            if (f_valid_w !== 1'b1 || f_pc_w !== WEXP[k-2] || f_instr_w !== WEXP[k-2] + 32'h1000) begin
               n_fail++;
               $display("FAIL wrap_head k=%0d: valid=%0b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                        k, f_valid_w, f_pc_w, f_instr_w, WEXP[k-2], WEXP[k-2] + 32'h1000);
            end
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      reset_w = 1'b0; stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0; ack_w = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_ack_delay();
      test_redirect();
      test_async_reset();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
